mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 112 +++++++++++
 tb/tb_mem_responder.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave with a fixed WAIT_CYCLES+1 clock response latency.
// Request fields are latched on acceptance; ack/err/rdata are valid only in the one-cycle RESP state.
module mem_responder #(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  be,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err
);

  localparam int          DEPTH     = 2 ** ADDR_W;
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic [31:0] mem [DEPTH];

  logic [31:0]       off;
  logic [31:0]       word;
  logic [ADDR_W-1:0] idx;
  logic              bad;

  // Address decode works on the latched address so late input changes cannot leak in.
  always_comb begin
    off  = addr_q - BASE_ADDR;
    word = off >> 2;
    idx  = word[ADDR_W-1:0];
    bad  = (addr_q[1:0] != 2'b00) || ((word >> ADDR_W) != 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
        be_q    <= be;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          accept = 1'b1;
          if (WAIT_CYCLES > 0) begin
            state_nxt = WAIT;
            cnt_nxt   = WAIT_INIT;
          end else begin
            state_nxt = RESP;
          end
        end
      end
      WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) begin
          cnt_nxt   = 4'd0;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ack   = (state == RESP);
    err   = ack && bad;
    rdata = (ack && !we_q && !bad) ? mem[idx] : 32'd0;
  end

  // Memory has no reset; the write lands on the edge that leaves RESP.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q && !bad) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default build (WAIT_CYCLES=2) and a zero-wait build side by side.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_a, req_b;
  logic        we;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic [31:0] rdata_a, rdata_b;
  logic        ack_a, ack_b, err_a, err_b;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_responder dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata_a), .ack(ack_a), .err(err_a)
  );

  mem_responder #(.WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .addr(addr), .wdata(wdata), .be(be),
    .rdata(rdata_b), .ack(ack_b), .err(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete transaction; the request fields are scrambled right after acceptance.
  task automatic txn(input bit sel, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic [31:0] exp_rd, input logic exp_err,
                     input int exp_lat, input string tag);
    int   n;
    bit   seen;
    logic ack_s, err_s;
    logic [31:0] rd_s;
    @(negedge clk);
    we = w; addr = a; wdata = d; be = b;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    n = 0; seen = 1'b0;
    rd_s = 32'd0; err_s = 1'b0;
    while (!seen && n < 40) begin
      @(posedge clk); #1; n++;
      if (n == 1) begin
        we = ~w; addr = 32'h4; wdata = 32'hA5A5_A5A5; be = 4'hF;
      end
      ack_s = sel ? ack_b : ack_a;
      err_s = sel ? err_b : err_a;
      rd_s  = sel ? rdata_b : rdata_a;
      if (ack_s) seen = 1'b1;
      else begin
        check({tag, " wait rdata"}, rd_s, 32'd0);
        check({tag, " wait err"}, {31'd0, err_s}, 32'd0);
      end
    end
    req_a = 1'b0; req_b = 1'b0;
    check({tag, " ack"}, {31'd0, seen}, 32'd1);
    check({tag, " latency"}, n, exp_lat);
    check({tag, " rdata"}, rd_s, exp_rd);
    check({tag, " err"}, {31'd0, err_s}, {31'd0, exp_err});
    @(posedge clk); #1;
    ack_s = sel ? ack_b : ack_a;
    check({tag, " ack pulse"}, {31'd0, ack_s}, 32'd0);
  endtask

  logic [31:0] b2b_addr [3];
  logic [31:0] b2b_exp  [3];
  int          b2b_t    [3];

  initial begin
    reset = 1'b1; req_a = 1'b0; req_b = 1'b0;
    we = 1'b0; addr = 32'd0; wdata = 32'd0; be = 4'd0;
    #12;
    check("rst ack_a", {31'd0, ack_a}, 32'd0);
    check("rst err_a", {31'd0, err_a}, 32'd0);
    check("rst rdata_a", rdata_a, 32'd0);
    check("rst ack_b", {31'd0, ack_b}, 32'd0);
    check("rst err_b", {31'd0, err_b}, 32'd0);
    check("rst rdata_b", rdata_b, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Full write then read-back, byte write, empty byte-enable write.
    txn(0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, 3, "a wr full");
    txn(0, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 3, "a rd full");
    txn(0, 1, 32'h10, 32'h0000_0055, 4'b0001, 32'd0, 0, 3, "a wr byte0");
    txn(0, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BE55, 0, 3, "a rd byte0");
    txn(0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 32'd0, 0, 3, "a wr be0");
    txn(0, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BE55, 0, 3, "a rd be0");

    // Error cases leave memory alone.
    txn(0, 0, 32'h12, 32'd0, 4'hF, 32'd0, 1, 3, "a rd misalign");
    txn(0, 0, 32'h1000, 32'd0, 4'hF, 32'd0, 1, 3, "a rd range");
    txn(0, 1, 32'h11, 32'h0, 4'hF, 32'd0, 1, 3, "a wr misalign");
    txn(0, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BE55, 0, 3, "a rd after err");

    // Reset during WAIT aborts the write.
    txn(0, 1, 32'h20, 32'h1234_5678, 4'hF, 32'd0, 0, 3, "a wr 20");
    @(negedge clk);
    we = 1'b1; addr = 32'h20; wdata = 32'hFFFF_FFFF; be = 4'hF; req_a = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1; #1;
    check("a rst wait ack", {31'd0, ack_a}, 32'd0);
    req_a = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("a post-rst ack", {31'd0, ack_a}, 32'd0);
    end
    txn(0, 0, 32'h20, 32'd0, 4'h0, 32'h1234_5678, 0, 3, "a rd 20");

    // Zero-wait build, plus asynchronous reset landing inside RESP.
    txn(1, 1, 32'h10, 32'hDEAD_BEEF, 4'hF, 32'd0, 0, 1, "b wr");
    txn(1, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 1, "b rd");
    @(negedge clk);
    we = 1'b1; addr = 32'h10; wdata = 32'h0; be = 4'hF; req_b = 1'b1;
    @(posedge clk); #1;
    check("b resp ack", {31'd0, ack_b}, 32'd1);
    reset = 1'b1; #1;
    check("b async rst ack", {31'd0, ack_b}, 32'd0);
    check("b async rst err", {31'd0, err_b}, 32'd0);
    check("b async rst rdata", rdata_b, 32'd0);
    req_b = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    txn(1, 0, 32'h10, 32'd0, 4'h0, 32'hDEAD_BEEF, 0, 1, "b rd after rst");

    // Back-to-back reads with req held high.
    b2b_addr[0] = 32'h10; b2b_exp[0] = 32'hDEAD_BE55;
    b2b_addr[1] = 32'h20; b2b_exp[1] = 32'h1234_5678;
    b2b_addr[2] = 32'h10; b2b_exp[2] = 32'hDEAD_BE55;
    @(negedge clk);
    we = 1'b0; be = 4'h0; addr = b2b_addr[0]; req_a = 1'b1;
    for (int i = 0; i < 3; i++) begin
      int n;
      n = 0;
      while (!ack_a && n < 40) begin
        @(posedge clk); #1; n++;
      end
      check("b2b ack", {31'd0, ack_a}, 32'd1);
      check("b2b rdata", rdata_a, b2b_exp[i]);
      b2b_t[i] = cyc;
      if (i < 2) addr = b2b_addr[i+1];
      else req_a = 1'b0;
      @(posedge clk); #1;
    end
    check("b2b spacing 1", b2b_t[1] - b2b_t[0], 32'd4);
    check("b2b spacing 2", b2b_t[2] - b2b_t[1], 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
